// File: rtl/trng_pkg.sv
// Shared defaults and Von Neumann pair-state encoding for the TRNG conditioner.
package trng_pkg;

    localparam int unsigned OUT_W_DEFAULT     = 8;
    localparam int unsigned REP_LIMIT_DEFAULT = 16;

    // Von Neumann pairing stage: waiting for the first bit, or holding it.
    localparam logic [0:0] PAIR_EMPTY = 1'b0;
    localparam logic [0:0] PAIR_HALF  = 1'b1;

endpackage

// File: rtl/trng_rct.sv
// Repetition-count health test on accepted raw bits; sticky failure flag.
module trng_rct
    import trng_pkg::*;
#(
    parameter int unsigned REP_LIMIT = REP_LIMIT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic bit_in,
    input  logic bit_stb,
    output logic health_fail
);

    logic [7:0] rep_cnt_q, rep_cnt_d;
    logic       last_q;
    logic       have_q;
    logic       fail_q;

    // Next run length: restart on a new value, saturate on a long run.
    always_comb begin
        rep_cnt_d = 8'd1;
        if (have_q && (bit_in == last_q)) begin
            rep_cnt_d = (rep_cnt_q == 8'hff) ? rep_cnt_q : rep_cnt_q + 8'd1;
        end
    end

    // Run-length history; failure is flagged alongside the count update so it is
    // visible on the cycle after the offending bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            rep_cnt_q <= 8'd0;
            last_q    <= 1'b0;
            have_q    <= 1'b0;
            fail_q    <= 1'b0;
        end else if (!enable) begin
            rep_cnt_q <= 8'd0;
            have_q    <= 1'b0;
        end else if (bit_stb) begin
            rep_cnt_q <= rep_cnt_d;
            last_q    <= bit_in;
            have_q    <= 1'b1;
            if (32'(rep_cnt_d) >= REP_LIMIT) begin
                fail_q <= 1'b1;
            end
        end
    end

    assign health_fail = fail_q;

endmodule

// File: rtl/trng_conditioner.sv
// Raw TRNG bit conditioner: Von Neumann debiasing, word packing, RCT health test.
module trng_conditioner
    import trng_pkg::*;
#(
    parameter int unsigned OUT_W     = OUT_W_DEFAULT,
    parameter int unsigned REP_LIMIT = REP_LIMIT_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic [OUT_W-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             health_fail,
    output logic             overrun
);

    localparam int unsigned CNT_W = $clog2(OUT_W + 1);

    logic             accept;
    logic [0:0]       vn_state_q;
    logic             vn_first_q;
    logic             emit_q;
    logic             emit_bit_q;
    logic [OUT_W-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [OUT_W-1:0] data_out_q, data_out_d;
    logic             data_valid_q, data_valid_d;
    logic             overrun_q, overrun_d;
    logic             full;
    logic             xfer;
    logic             load;

    assign accept = enable && bit_valid && !health_fail;

    trng_rct #(
        .REP_LIMIT (REP_LIMIT)
    ) u_rct (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .bit_in      (bit_in),
        .bit_stb     (accept),
        .health_fail (health_fail)
    );

    // Von Neumann pairing; the debiased bit is registered toward the packer.
    always_ff @(posedge clk) begin
        if (rst) begin
            vn_state_q <= PAIR_EMPTY;
            vn_first_q <= 1'b0;
            emit_q     <= 1'b0;
            emit_bit_q <= 1'b0;
        end else begin
            emit_q <= 1'b0;
            if (health_fail || !enable) begin
                vn_state_q <= PAIR_EMPTY;
            end else if (accept) begin
                if (vn_state_q == PAIR_EMPTY) begin
                    vn_state_q <= PAIR_HALF;
                    vn_first_q <= bit_in;
                end else begin
                    vn_state_q <= PAIR_EMPTY;
                    if (bit_in != vn_first_q) begin
                        emit_q     <= 1'b1;
                        emit_bit_q <= vn_first_q;
                    end
                end
            end
        end
    end

    assign full = (bit_cnt_q == CNT_W'(OUT_W));
    assign xfer = data_valid_q && data_ready;
    assign load = full && (!data_valid_q || data_ready) && !health_fail;

    // Packer and output slot: a full word moves out when the slot frees up; a bit
    // arriving with nowhere to go is dropped and flagged.
    always_comb begin
        shreg_d      = shreg_q;
        bit_cnt_d    = bit_cnt_q;
        data_out_d   = data_out_q;
        data_valid_d = data_valid_q;
        overrun_d    = 1'b0;
        if (xfer) begin
            data_valid_d = 1'b0;
        end
        if (health_fail) begin
            shreg_d   = '0;
            bit_cnt_d = '0;
        end else begin
            if (load) begin
                data_out_d   = shreg_q;
                data_valid_d = 1'b1;
                shreg_d      = '0;
                bit_cnt_d    = '0;
            end
            if (emit_q) begin
                if (!full || load) begin
                    shreg_d   = {shreg_d[OUT_W-2:0], emit_bit_q};
                    bit_cnt_d = bit_cnt_d + CNT_W'(1);
                end else begin
                    overrun_d = 1'b1;
                end
            end
        end
    end

    // Packer and output register state.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q      <= '0;
            bit_cnt_q    <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            shreg_q      <= shreg_d;
            bit_cnt_q    <= bit_cnt_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            overrun_q    <= overrun_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_trng_conditioner.sv
// Self-checking bench for trng_conditioner against a queue-based reference model.
module tb_trng_conditioner;

    localparam int unsigned OUT_W     = 8;
    localparam int unsigned REP_LIMIT = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             enable;
    logic             bit_in;
    logic             bit_valid;
    logic [OUT_W-1:0] data_out;
    logic             data_valid;
    logic             data_ready;
    logic             health_fail;
    logic             overrun;

    always #5 clk = ~clk;

    trng_conditioner #(
        .OUT_W     (OUT_W),
        .REP_LIMIT (REP_LIMIT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .bit_in      (bit_in),
        .bit_valid   (bit_valid),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .health_fail (health_fail),
        .overrun     (overrun)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int valid_cycles;
    int ovr_cycles;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: emitted bits collect in a queue; the output slot is one word.
    bit               m_half, m_first, m_pend, m_pend_bit;
    bit               m_valid, m_fail, m_ovr, m_last, m_have;
    int               m_rep;
    logic [OUT_W-1:0] m_out;
    bit               sr[$];

    function automatic logic [OUT_W-1:0] pack_sr();
        logic [OUT_W-1:0] v;
        v = '0;
        foreach (sr[i]) v = {v[OUT_W-2:0], sr[i]};
        return v;
    endfunction

    task automatic model_step(input bit r, input bit en, input bit bv, input bit b, input bit rdy);
        bit acc, xfer, load, drop, n_pend, n_pend_bit;
        if (r) begin
            m_half = 0; m_first = 0; m_pend = 0; m_pend_bit = 0;
            m_valid = 0; m_fail = 0; m_ovr = 0; m_last = 0; m_have = 0;
            m_rep = 0; m_out = '0; sr.delete();
        end else begin
            acc        = en && bv && !m_fail;
            xfer       = m_valid && rdy;
            drop       = 0;
            n_pend     = 0;
            n_pend_bit = m_pend_bit;
            if (xfer) m_valid = 0;
            if (m_fail) begin
                sr.delete();
                m_half = 0;
            end else begin
                load = (sr.size() == OUT_W) && (!m_valid || rdy);
                if (load) begin
                    m_out   = pack_sr();
                    m_valid = 1;
                    sr.delete();
                end
                if (m_pend) begin
                    if (sr.size() < OUT_W) sr.push_back(m_pend_bit);
                    else drop = 1;
                end
                if (!en) m_half = 0;
                else if (acc) begin
                    if (!m_half) begin
                        m_half  = 1;
                        m_first = b;
                    end else begin
                        m_half = 0;
                        if (b != m_first) begin
                            n_pend     = 1;
                            n_pend_bit = m_first;
                        end
                    end
                end
            end
            if (!en) begin
                m_have = 0;
                m_rep  = 0;
            end else if (acc) begin
                m_rep  = (m_have && b == m_last) ? ((m_rep < 255) ? m_rep + 1 : 255) : 1;
                m_last = b;
                m_have = 1;
                if (m_rep >= REP_LIMIT) m_fail = 1;
            end
            m_pend     = n_pend;
            m_pend_bit = n_pend_bit;
            m_ovr      = drop;
        end
    endtask

    // One clock: drive, advance the model, then compare every output.
    task automatic step(input bit r, input bit en, input bit bv, input bit b, input bit rdy);
        rst = r; enable = en; bit_valid = bv; bit_in = b; data_ready = rdy;
        @(posedge clk);
        model_step(r, en, bv, b, rdy);
        #1;
        check_eq("data_valid", 32'(data_valid), 32'(m_valid));
        check_eq("data_out", 32'(data_out), 32'(m_out));
        check_eq("health_fail", 32'(health_fail), 32'(m_fail));
        check_eq("overrun", 32'(overrun), 32'(m_ovr));
        if (data_valid) valid_cycles++;
        if (overrun) ovr_cycles++;
    endtask

    task automatic feed(input bit b, input bit rdy);
        step(0, 1, 1, b, rdy);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(0, 1, 0, 0, rdy);
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        valid_cycles = 0;
        ovr_cycles   = 0;
    endtask

    // Emit n debiased bits using random 01/10 pairs.
    task automatic feed_pairs(input int n, input bit rdy);
        bit b;
        for (int i = 0; i < n; i++) begin
            b = 1'($urandom_range(0, 1));
            feed(b, rdy);
            feed(!b, rdy);
        end
    endtask

    initial begin
        logic [15:0] s030;
        logic [7:0]  s031;
        do_reset();
        check_eq("reset_data_valid", 32'(data_valid), 32'd0);
        check_eq("reset_health_fail", 32'(health_fail), 32'd0);

        // Known 16-bit stream, consumer always ready.
        s030 = 16'b0110_1001_0110_1010;
        for (int i = 15; i >= 0; i--) feed(s030[i], 1);
        idle(4, 1);
        check_eq("stream_word_valid_cycles", 32'(valid_cycles), 32'd1);

        // Equal pairs are all discarded.
        do_reset();
        s031 = 8'b0011_0011;
        for (int i = 7; i >= 0; i--) feed(s031[i], 1);
        idle(3, 1);
        check_eq("equal_pairs_no_word", 32'(valid_cycles), 32'd0);

        // Enable dropped mid-pair discards the half pair.
        do_reset();
        feed(1, 1);
        step(0, 0, 0, 0, 1);
        feed_pairs(8, 1);
        idle(4, 1);
        check_eq("enable_gap_one_word", 32'(valid_cycles), 32'd1);

        // Backpressure: two words plus one extra bit drops exactly one bit.
        do_reset();
        feed_pairs(17, 0);
        idle(3, 0);
        check_eq("overrun_pulses", 32'(ovr_cycles), 32'd1);
        idle(6, 1);

        // Reset with a word pending and a half pair held.
        do_reset();
        feed_pairs(8, 0);
        idle(2, 0);
        feed(1, 0);
        step(1, 0, 0, 0, 0);
        check_eq("rst_mid_valid", 32'(data_valid), 32'd0);
        valid_cycles = 0;
        feed_pairs(8, 1);
        idle(4, 1);
        check_eq("post_rst_one_word", 32'(valid_cycles), 32'd1);

        // Sixteen identical bits trip the health test; nothing follows.
        do_reset();
        for (int i = 0; i < 15; i++) feed(1, 1);
        check_eq("rct_not_yet", 32'(health_fail), 32'd0);
        feed(1, 1);
        check_eq("rct_trip", 32'(health_fail), 32'd1);
        valid_cycles = 0;
        for (int i = 0; i < 32; i++) feed(1'(i % 2), 1);
        idle(4, 1);
        check_eq("no_word_after_fail", 32'(valid_cycles), 32'd0);

        // Randomized traffic with occasional resets.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(0, 299) == 0), ($urandom_range(0, 19) != 0),
                 ($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 9) < 6));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
